msb_scan_ctrl: RTL and testbench

//  Time-multiplexed MSB finder: shares one msb_8bit unit across the N/8 bytes of a word.

---
 rtl/msb_scan_ctrl_pkg.sv | 26 ++
 rtl/msb_scan_ctrl_msb_8bit.sv | 12 +
 rtl/msb_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_msb_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/msb_scan_ctrl_pkg.sv
// Shared definitions for the time-multiplexed MSB scanner: FSM encoding,
// byte width and the 8-bit priority encoder used by the shared finder.
package msb_scan_ctrl_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } scan_state_e;

   // 1-based position of the highest set bit in a byte, 0 when the byte is zero.
   // Lower bits are visited first, so the highest set bit is the last one written.
   function automatic logic [3:0] msb8_pos(input logic [7:0] b);
      logic [3:0] p;
      p = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = 4'(i + 1);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/msb_scan_ctrl_msb_8bit.sv
// Combinational 8-bit MSB finder: 1-based position of the highest set bit,
// 0 when no bit is set. One instance is shared across all bytes of a word.
module msb_8bit
   import msb_scan_ctrl_pkg::*;
(
   input  logic [7:0] byte_in,
   output logic [3:0] pos
);

   assign pos = msb8_pos(byte_in);

endmodule

// File: rtl/msb_scan_ctrl.sv
// Time-multiplexed MSB finder. A word is captured on the input handshake,
// then scanned one byte per clock from the most significant byte downwards
// through a single msb_8bit. The first non-zero byte ends the scan and the
// 1-based bit position is presented on the output handshake.
module msb_scan_ctrl
   import msb_scan_ctrl_pkg::*;
#(
   parameter int N     = 32,
   parameter int POS_W = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_zero,
   output logic             busy
);

   localparam int BYTES = N / BYTE_W;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(BYTES - 1);

   scan_state_e      state_r, state_nxt_s;
   logic [N-1:0]     data_r;
   logic [IDX_W-1:0] idx_r, idx_nxt_s;
   logic             capture_s;
   logic             out_valid_r, out_valid_nxt_s;
   logic [POS_W-1:0] out_pos_r, out_pos_nxt_s;
   logic             out_zero_r, out_zero_nxt_s;
   logic [7:0]       byte_s;
   logic [3:0]       part_s;
   logic [POS_W-1:0] cand_pos_s;

   // Byte mux: the captured byte under the scan index feeds the shared finder.
   assign byte_s = data_r[{idx_r, 3'b000} +: BYTE_W];

   msb_8bit u_msb_8bit (
      .byte_in (byte_s),
      .pos     (part_s)
   );

   // Bit position of the candidate: byte offset (idx*8) plus the in-byte position.
   assign cand_pos_s = POS_W'({idx_r, 3'b000}) + POS_W'(part_s);

   // Next-state and result logic for the IDLE/SCAN/DONE sequence.
   always_comb begin
      state_nxt_s     = state_r;
      idx_nxt_s       = idx_r;
      capture_s       = 1'b0;
      out_valid_nxt_s = out_valid_r;
      out_pos_nxt_s   = out_pos_r;
      out_zero_nxt_s  = out_zero_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid && !flush) begin
               capture_s   = 1'b1;
               idx_nxt_s   = IDX_TOP;
               state_nxt_s = ST_SCAN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (flush) begin
               state_nxt_s     = ST_IDLE;
               out_valid_nxt_s = 1'b0;
               out_pos_nxt_s   = {POS_W{1'b0}};
               out_zero_nxt_s  = 1'b0;
            end else if (part_s != 4'd0) begin
               state_nxt_s     = ST_DONE;
               out_valid_nxt_s = 1'b1;
               out_pos_nxt_s   = cand_pos_s;
               out_zero_nxt_s  = 1'b0;
            end else if (idx_r == {IDX_W{1'b0}}) begin
               state_nxt_s     = ST_DONE;
               out_valid_nxt_s = 1'b1;
               out_pos_nxt_s   = {POS_W{1'b0}};
               out_zero_nxt_s  = 1'b1;
            end else begin
               idx_nxt_s = idx_r - IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (flush) begin
               state_nxt_s     = ST_IDLE;
               out_valid_nxt_s = 1'b0;
               out_pos_nxt_s   = {POS_W{1'b0}};
               out_zero_nxt_s  = 1'b0;
            end else if (out_ready) begin
               state_nxt_s     = ST_IDLE;
               out_valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            out_valid_nxt_s = 1'b0;
            out_pos_nxt_s   = {POS_W{1'b0}};
            out_zero_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, scan index, captured word and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= {IDX_W{1'b0}};
         data_r      <= {N{1'b0}};
         out_valid_r <= 1'b0;
         out_pos_r   <= {POS_W{1'b0}};
         out_zero_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_pos_r   <= out_pos_nxt_s;
         out_zero_r  <= out_zero_nxt_s;
         if (capture_s) begin
            data_r <= in_data;
         end else begin
            data_r <= data_r;
         end
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign out_valid = out_valid_r;
   assign out_pos   = out_pos_r;
   assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_msb_scan_ctrl.sv
// Self-checking bench for msb_scan_ctrl (N=32): directed cases followed by
// randomized words, each checked against a bit-level reference model.
module tb_msb_scan_ctrl;

   localparam int N     = 32;
   localparam int POS_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [POS_W-1:0] out_pos;
   logic             out_zero;
   logic             busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   msb_scan_ctrl #(.N(N), .POS_W(POS_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pos   (out_pos),
      .out_zero  (out_zero),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: highest set bit of the whole word, and scan length from the
   // highest non-zero byte j (N/8 - j), or N/8 for a zero word.
   task automatic model(input logic [31:0] d, output logic [7:0] p, output logic z,
                        output int cyc);
      p   = 8'd0;
      z   = 1'b1;
      cyc = N / 8;
      for (int i = N - 1; i >= 0; i--) begin
         if (d[i] && z) begin
            p   = 8'(i + 1);
            z   = 1'b0;
            cyc = (N / 8) - (i / 8);
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_pos"},   32'(out_pos),   32'd0);
      chk({tag, "_out_zero"},  32'(out_zero),  32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
   endtask

   // Send one word, check latency and result, stall `hold` cycles in DONE
   // with in_valid asserted, then complete the output handshake.
   task automatic send(input logic [31:0] d, input int hold, input string tag);
      logic [7:0] ep;
      logic       ez;
      int         ecyc;
      int         lat;
      model(d, ep, ez, ecyc);
      chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(ecyc));
      chk({tag, "_pos"},     32'(out_pos), 32'(ep));
      chk({tag, "_zero"},    32'(out_zero), 32'(ez));
      in_valid = 1'b1;
      in_data  = $urandom;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"},    32'(out_valid), 32'd1);
         chk({tag, "_hold_pos"},      32'(out_pos),   32'(ep));
         chk({tag, "_hold_in_ready"}, 32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_post_valid"},    32'(out_valid), 32'd0);
      chk({tag, "_post_in_ready"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      int          seen;
      int          w;
      logic [31:0] rd;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      send(32'h8000_0000, 0, "t1_msb");
      send(32'h0012_3400, 0, "t2_mid");
      send(32'h0000_0001, 0, "t3_lsb");
      send(32'h0000_0000, 0, "t3_zero");
      send(32'h0000_00A0, 5, "t4_stall");

      // flush in IDLE blocks acceptance for that edge
      in_valid = 1'b1;
      in_data  = 32'h0000_00FF;
      flush    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("idle_flush_busy", 32'(busy), 32'd0);
      chk("idle_flush_in_ready", 32'(in_ready), 32'd1);

      // flush in the second SCAN cycle
      in_valid = 1'b1;
      in_data  = 32'h0000_00FF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_busy_scan2", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_reset_state("t5_flushed");
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1;
      end
      chk("t5_no_valid", 32'(seen), 32'd0);
      send(32'h0000_0100, 0, "t5_next");

      // flush in DONE clears the held result
      in_valid = 1'b1;
      in_data  = 32'h8000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("done_flush_pre_valid", 32'(out_valid), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_reset_state("done_flush");

      // rst in SCAN
      in_valid = 1'b1;
      in_data  = 32'h0000_0001;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("rst_scan");

      // rst in DONE, holding a zero-word result (out_zero=1)
      in_valid = 1'b1;
      in_data  = 32'h0000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (out_valid !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("rst_done_pre_zero", 32'(out_zero), 32'd1);
      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_reset_state("rst_done");

      // back-to-back randomized words
      for (int n = 0; n < 40; n++) begin
         rd = $urandom;
         rd = rd >> $urandom_range(0, 32);
         send(rd, $urandom_range(0, 2), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
